// File: rtl/wordcount_beat_unpacker_if.sv
// Control, beat-input and word-output signals of the wordcount beat unpacker.
// The slave modport is the unpacker's view and the master modport is its driver's view.
interface wordcount_beat_unpacker_if #(
  parameter int C_DATA_WIDTH  = 512,
  parameter int C_WORD_WIDTH  = 128,
  parameter int C_COUNT_WIDTH = 32
);
  logic                     start;
  logic [C_COUNT_WIDTH-1:0] num_of_words;
  logic                     busy;
  logic                     done;
  logic                     short_err;

  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [C_DATA_WIDTH-1:0]  s_axis_tdata;
  logic                     s_axis_tlast;

  logic                     m_word_valid;
  logic                     m_word_ready;
  logic [C_WORD_WIDTH-1:0]  m_word_data;
  logic                     m_word_last;
  logic [C_COUNT_WIDTH-1:0] m_word_index;

  modport slave (
    input  start, num_of_words, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_word_ready,
    output busy, done, short_err, s_axis_tready, m_word_valid, m_word_data, m_word_last,
           m_word_index
  );

  modport master (
    output start, num_of_words, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_word_ready,
    input  busy, done, short_err, s_axis_tready, m_word_valid, m_word_data, m_word_last,
           m_word_index
  );
endinterface

// File: rtl/wordcount_beat_unpacker.sv
// Splits wide read-master beats into fixed-width words, enforcing the host word count:
// padding in the final beat is trimmed, surplus beats are drained to tlast, and short transfers are flagged.
module wordcount_beat_unpacker #(
  parameter int C_DATA_WIDTH  = 512,
  parameter int C_WORD_WIDTH  = 128,
  parameter int C_COUNT_WIDTH = 32
) (
  input logic                      ap_clk,
  input logic                      areset,
  wordcount_beat_unpacker_if.slave bus
);
  localparam int RATIO  = C_DATA_WIDTH / C_WORD_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state;
  logic [C_DATA_WIDTH-1:0]  hold_data;
  logic                     hold_valid;
  logic                     hold_last;
  logic [LANE_W-1:0]        lane;
  logic [C_COUNT_WIDTH-1:0] remaining;
  logic [C_COUNT_WIDTH-1:0] index;
  logic                     short_err;

  logic [C_WORD_WIDTH-1:0]  word_sel;
  logic                     word_valid;
  logic                     word_last;
  logic                     word_fire;
  logic                     at_last_lane;
  logic                     last_rem;
  logic                     retire;
  logic                     job_end;
  logic                     beat_ready;
  logic                     beat_fire;

  assign word_valid   = (state == S_RUN) && hold_valid;
  assign at_last_lane = (lane == LAST_LANE);
  assign last_rem     = (remaining == C_COUNT_WIDTH'(1));
  assign word_last    = word_valid && (last_rem || (hold_last && at_last_lane));
  assign word_fire    = word_valid && bus.m_word_ready;
  assign retire       = word_fire && (at_last_lane || last_rem);
  assign job_end      = word_fire && word_last;

  // A new beat may land in the same cycle the current one retires, except on the job's final word.
  always_comb begin
    beat_ready = 1'b0;
    case (state)
      S_RUN:   beat_ready = !job_end && (!hold_valid || retire);
      S_DRAIN: beat_ready = 1'b1;
      default: beat_ready = 1'b0;
    endcase
  end

  assign beat_fire = bus.s_axis_tvalid && beat_ready;

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) word_sel = hold_data[i*C_WORD_WIDTH +: C_WORD_WIDTH];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state      <= S_IDLE;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      lane       <= '0;
      remaining  <= '0;
      index      <= '0;
      short_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            remaining  <= bus.num_of_words;
            index      <= '0;
            lane       <= '0;
            short_err  <= 1'b0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            state      <= (bus.num_of_words == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (word_fire) begin
            index     <= index + C_COUNT_WIDTH'(1);
            remaining <= (remaining != '0) ? remaining - C_COUNT_WIDTH'(1) : remaining;
            lane      <= retire ? '0 : lane + LANE_W'(1);
          end
          if (beat_fire) begin
            hold_data  <= bus.s_axis_tdata;
            hold_valid <= 1'b1;
            hold_last  <= bus.s_axis_tlast;
          end else if (retire) begin
            hold_valid <= 1'b0;
          end
          // Ending on a tlast lane with words still owed means the host over-asked.
          if (job_end) begin
            state <= hold_last ? S_DONE : S_DRAIN;
            if (hold_last && at_last_lane && !last_rem) short_err <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.s_axis_tvalid && bus.s_axis_tlast) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done          = (state == S_DONE);
  assign bus.short_err     = short_err;
  assign bus.s_axis_tready = beat_ready;
  assign bus.m_word_valid  = word_valid;
  assign bus.m_word_data   = word_sel;
  assign bus.m_word_last   = word_last;
  assign bus.m_word_index  = index;
endmodule

// File: tb/tb_wordcount_beat_unpacker.sv
// Bench for wordcount_beat_unpacker: directed jobs with a word scoreboard filled from a lane model
// and drained by a negedge monitor that checks every presented word, including while stalled.
module tb_wordcount_beat_unpacker;
  localparam int DW = 512;
  localparam int WW = 128;
  localparam int CW = 32;

  typedef struct {
    logic [WW-1:0] data;
    logic [CW-1:0] index;
    logic          last;
  } word_t;

  logic ap_clk;
  logic areset;

  wordcount_beat_unpacker_if #(.C_DATA_WIDTH(DW), .C_WORD_WIDTH(WW), .C_COUNT_WIDTH(CW)) bus ();

  wordcount_beat_unpacker #(.C_DATA_WIDTH(DW), .C_WORD_WIDTH(WW), .C_COUNT_WIDTH(CW)) dut (
    .ap_clk (ap_clk),
    .areset (areset),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  word_t         exp_q[$];
  logic [DW-1:0] beat_q[$];
  logic          last_q[$];

  bit rand_ready = 0;
  int hs_count;
  int first_hs_cyc;
  int last_word_cyc;
  int first_accept_cyc;
  int last_accept_cyc;
  int start_cyc;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    forever begin
      @(posedge ap_clk);
      cyc++;
    end
  end

  // Output-side ready: always high unless a job asks for random backpressure.
  initial begin
    bus.m_word_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      bus.m_word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [WW-1:0] observed,
                              input logic [WW-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every presented word is compared against the scoreboard head; it only pops on a handshake.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (!areset && bus.m_word_valid === 1'b1) begin
        check_output("word_expected", WW'(exp_q.size() != 0), WW'(1));
        if (exp_q.size() != 0) begin
          check_output("word_data", bus.m_word_data, exp_q[0].data);
          check_output("word_index", WW'(bus.m_word_index), WW'(exp_q[0].index));
          check_output("word_last", WW'(bus.m_word_last), WW'(exp_q[0].last));
          if (bus.m_word_ready === 1'b1) begin
            if (hs_count == 0) first_hs_cyc = cyc;
            if (exp_q[0].last) last_word_cyc = cyc;
            hs_count++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic make_beats(input int n);
    logic [DW-1:0] beat;
    beat_q.delete();
    last_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DW / 32; k++) beat[k*32 +: 32] = $urandom();
      beat_q.push_back(beat);
      last_q.push_back(i == n - 1);
    end
  endtask

  task automatic build_expect(input int num, output logic exp_short, output logic exp_drain);
    logic [DW-1:0] beat;
    word_t         w;
    int            rem;
    int            idx;
    bit            ended;
    rem = num;
    idx = 0;
    ended = (num == 0);
    exp_short = 1'b0;
    exp_drain = 1'b0;
    for (int b = 0; b < beat_q.size() && !ended; b++) begin
      beat = beat_q[b];
      for (int l = 0; l < DW / WW && !ended; l++) begin
        w.data  = beat[l*WW +: WW];
        w.index = CW'(idx);
        w.last  = (rem == 1) || (last_q[b] && l == DW / WW - 1);
        if (last_q[b] && l == DW / WW - 1 && rem != 1) exp_short = 1'b1;
        exp_q.push_back(w);
        if (w.last) begin
          ended = 1;
          exp_drain = !last_q[b];
        end
        rem--;
        idx++;
      end
    end
  endtask

  task automatic start_job(input int num);
    @(posedge ap_clk);
    #1;
    hs_count = 0;
    bus.start = 1'b1;
    bus.num_of_words = CW'(num);
    start_cyc = cyc;
    @(posedge ap_clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic apply_stimulus(input bit gaps);
    bit accepted;
    for (int b = 0; b < beat_q.size(); b++) begin
      if (gaps) begin
        bus.s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge ap_clk);
          #1;
        end
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = beat_q[b];
      bus.s_axis_tlast  = last_q[b];
      accepted = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge ap_clk);
        if (bus.s_axis_tready === 1'b1) begin
          accepted = 1;
          break;
        end
      end
      check_output("beat_accept", WW'(accepted), WW'(1));
      if (b == 0) first_accept_cyc = cyc;
      last_accept_cyc = cyc;
      @(posedge ap_clk);
      #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_for_done(input string tag, output int dcyc);
    bit seen;
    seen = 0;
    dcyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge ap_clk);
      if (bus.done === 1'b1) begin
        seen = 1;
        dcyc = cyc;
        break;
      end
    end
    check_output({tag, "_done_seen"}, WW'(seen), WW'(1));
    if (seen) begin
      check_output({tag, "_busy_at_done"}, WW'(bus.busy), WW'(0));
      @(negedge ap_clk);
      check_output({tag, "_done_pulse"}, WW'(bus.done), WW'(0));
    end
  endtask

  task automatic run_job(input string tag, input int num, input bit gaps, input bit rnd,
                         input bit check_tput);
    logic es;
    logic ed;
    int   dcyc;
    int   exp_done;
    exp_q.delete();
    build_expect(num, es, ed);
    rand_ready = rnd;
    start_job(num);
    check_output({tag, "_err_clear"}, WW'(bus.short_err), WW'(0));
    if (num != 0) begin
      check_output({tag, "_busy"}, WW'(bus.busy), WW'(1));
    end else begin
      check_output({tag, "_zero_tready"}, WW'(bus.s_axis_tready), WW'(0));
      check_output({tag, "_zero_valid"}, WW'(bus.m_word_valid), WW'(0));
    end
    apply_stimulus(gaps);
    wait_for_done(tag, dcyc);
    rand_ready = 0;
    if (num == 0) exp_done = start_cyc + 1;
    else if (ed) exp_done = last_accept_cyc + 1;
    else exp_done = last_word_cyc + 1;
    check_output({tag, "_done_cycle"}, WW'(dcyc), WW'(exp_done));
    check_output({tag, "_words_left"}, WW'(exp_q.size()), WW'(0));
    check_output({tag, "_short_err"}, WW'(bus.short_err), WW'(es));
    if (check_tput) begin
      check_output({tag, "_latency"}, WW'(first_hs_cyc), WW'(first_accept_cyc + 1));
      check_output({tag, "_throughput"}, WW'(last_word_cyc - first_hs_cyc), WW'(num - 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_tready"}, WW'(bus.s_axis_tready), WW'(0));
    check_output({tag, "_valid"}, WW'(bus.m_word_valid), WW'(0));
    check_output({tag, "_last"}, WW'(bus.m_word_last), WW'(0));
    check_output({tag, "_busy"}, WW'(bus.busy), WW'(0));
    check_output({tag, "_done"}, WW'(bus.done), WW'(0));
    check_output({tag, "_short_err"}, WW'(bus.short_err), WW'(0));
    check_output({tag, "_data"}, bus.m_word_data, WW'(0));
    check_output({tag, "_index"}, WW'(bus.m_word_index), WW'(0));
  endtask

  initial begin
    logic es;
    logic ed;
    areset = 1'b1;
    bus.start = 1'b0;
    bus.num_of_words = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tlast = 1'b0;
    hs_count = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    $display("[TB] reset values");
    check_idle_outputs("reset");
    areset = 1'b0;
    @(posedge ap_clk);
    #1;

    $display("[TB] exact fit");
    make_beats(2);
    run_job("exact", 8, 0, 0, 1);

    $display("[TB] trim");
    make_beats(2);
    run_job("trim", 5, 0, 0, 0);

    $display("[TB] drain");
    make_beats(3);
    run_job("drain", 4, 0, 0, 0);

    $display("[TB] short transfer");
    make_beats(2);
    run_job("short", 10, 0, 0, 0);

    $display("[TB] zero words");
    make_beats(0);
    run_job("zero", 0, 0, 0, 0);

    $display("[TB] backpressure");
    make_beats(4);
    run_job("bp", 16, 1, 1, 0);

    $display("[TB] reset mid-job");
    make_beats(4);
    exp_q.delete();
    build_expect(16, es, ed);
    start_job(16);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = beat_q[0];
    bus.s_axis_tlast  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk);
      if (bus.s_axis_tready === 1'b1) break;
    end
    @(posedge ap_clk);
    #1;
    bus.s_axis_tdata = beat_q[1];
    for (int i = 0; i < 50; i++) begin
      if (hs_count >= 4) break;
      @(posedge ap_clk);
      #1;
    end
    check_output("rst_words_before", WW'(hs_count >= 4), WW'(1));
    areset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    @(posedge ap_clk);
    #1;
    check_idle_outputs("rst_mid");
    @(posedge ap_clk);
    #1;
    areset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check_output("rst_no_done", WW'(bus.done), WW'(0));
    end

    $display("[TB] restart after reset");
    make_beats(1);
    run_job("restart", 4, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wordcount_beat_unpacker.md
# wordcount_beat_unpacker

Splits the 512-bit AXI4-Stream beats delivered by the wordcount kernel's AXI read master into a stream of fixed-width words, one word per handshake, for the word-count/KVS lookup datapath. Sits between the read master's `m_axis` output and the wordcount control/lookup logic. Enforces the host-supplied word count: it trims padding in the final beat, drains surplus beats up to `tlast`, and flags short transfers.

## Interface
- `C_DATA_WIDTH`, 512, input beat width in bits.
- `C_WORD_WIDTH`, 128, output word width; `RATIO = C_DATA_WIDTH/C_WORD_WIDTH` must be a power of two ≥1.
- `C_COUNT_WIDTH`, 32, width of the word count and the index.

Ports:
- `ap_clk`  in  1  clock.
- `areset`  in  1  reset: synchronous, active-high, sampled on `ap_clk`.
- `start`  in  1  one-cycle pulse; ignored unless IDLE.
- `num_of_words`  in  C_COUNT_WIDTH  number of words to emit; sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `short_err`  out  1  sticky: input `tlast` arrived before `num_of_words` words were emitted; cleared on `start`.
- `s_axis_tvalid`  in  1, `s_axis_tready`  out  1, `s_axis_tdata`  in  C_DATA_WIDTH, `s_axis_tlast`  in  1: beat input.
- `m_word_valid`  out  1, `m_word_ready`  in  1, `m_word_data`  out  C_WORD_WIDTH: word output.
- `m_word_last`  out  1  marks the final word of the job.
- `m_word_index`  out  C_COUNT_WIDTH  0-based index of the current word.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN** on `start` with `num_of_words` ≠ 0. `start` latches `remaining = num_of_words`, clears the index and clears `short_err`.
- **IDLE → DONE** on `start` with `num_of_words` = 0. No beats are accepted and no words are emitted.
- **Holding register:** one register of C_DATA_WIDTH bits, plus `hold_valid`, `hold_last` (copy of the beat's `tlast`), and a lane counter.
- **Lane order:** lane `i` = `tdata[i*C_WORD_WIDTH +: C_WORD_WIDTH]`, emitted lane 0 first.
- **Output:** `m_word_valid = hold_valid` in RUN. `m_word_data` = holding register selected by the lane counter.
- **Per output handshake:** lane counter +1, index +1, `remaining` −1.
- **Beat retirement:** a beat retires on the handshake of lane RATIO−1, or on the handshake where `remaining` reaches 0. Any unconsumed lanes are discarded.
- **`m_word_last` is asserted when either:**
  - `remaining` = 1, or
  - `hold_last` = 1 and lane = RATIO−1 (short transfer). In this case `short_err` is set on that handshake, unless `remaining` = 1 at the same time.
- **After the last word:**
  - If the retiring beat had `hold_last` = 1, go to DONE.
  - Otherwise go to DRAIN. In DRAIN, `s_axis_tready` = 1 and beats are discarded until a beat with `tlast` is accepted, then go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE.
- **`start` outside IDLE** is ignored.
- **`areset` at any time:**
  - state → IDLE.
  - `hold_valid`, counters and `short_err` cleared.
  - In-flight data lost; no `done` is generated.

## Timing
- **Reset values:** `s_axis_tready`, `m_word_valid`, `m_word_last`, `busy`, `done`, `short_err` = 0. `m_word_data` and `m_word_index` = 0.
- **`s_axis_tready`:**
  - In RUN it equals `!hold_valid` OR (`m_word_valid` & `m_word_ready` & retiring handshake), and is 0 once `remaining` reaches 0.
  - It is 1 in DRAIN and 0 in IDLE/DONE.
  - It depends combinationally on `m_word_ready`. No other output path is combinational from inputs.
- **Latency:** a beat accepted at cycle N presents its lane 0 at cycle N+1.
- **Throughput:** one word per cycle with continuous input and ready output. There is no bubble at beat boundaries: a retiring handshake and a new beat acceptance may occur in the same cycle.
- **`m_word_*` stability:** stable while `m_word_valid` & !`m_word_ready`.
- **Handshake rule:** `m_word_valid` never depends on `m_word_ready`.
- **`done`:** asserted the cycle after the final event, which is either the last word handshake (when `hold_last` = 1) or the `tlast` beat accepted in DRAIN.
- **`busy`:** drops in the same cycle `done` rises.
- **Counters:** the index wraps modulo 2^C_COUNT_WIDTH. `remaining` never underflows.

## Test plan
- **Exact fit:** `num_of_words`=8, two beats with `tlast` on beat 2, `m_word_ready`=1 → 8 words over 8 consecutive cycles, index 0..7, `m_word_last` only at index 7, `done` one cycle after, `short_err`=0.
- **Trim:** `num_of_words`=5, two beats with `tlast` on beat 2 → words = beat1 lanes 0–3 then beat2 lane 0, `m_word_last` at index 4, lanes 1–3 of beat 2 never emitted, `done` follows.
- **Drain:** `num_of_words`=4, three beats with `tlast` on beat 3 → 4 words, then beats 2–3 accepted with no output, `done` the cycle after beat 3 is accepted.
- **Short:** `num_of_words`=10, two beats with `tlast` on beat 2 → 8 words, `m_word_last` at index 7, `short_err`=1, `done` pulses.
- **Zero and backpressure:** `num_of_words`=0 → `done` at start+1, `s_axis_tready` and `m_word_valid` never high. Then `num_of_words`=16 with random `m_word_ready` and `tvalid` gaps → data and order match the reference model, with outputs held stable while stalled.
- **Reset mid-job:** assert `areset` after word 3 of a 16-word job → all outputs 0 next cycle, no `done`. A new `start` with `num_of_words`=4 then completes normally from index 0.
